fetch_unit: RTL
===============

Name: fetch_unit

Overview:
- IF stage plus IF/ID pipeline register of the 5-stage MIPS pipeline; sits directly downstream of hazard_unit.
- Consumes stallF, stallD and flash from hazard_unit. Also consumes the branch target from EX.
- Owns the PC, drives instruction-memory fetches, and produces the instruction/PC+4 pair that DE decodes.
- Buffers a fetched word across stalls so a stalled fetch is never re-issued.

Parameters:
- PC_RESET, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0000, instruction word inserted as a bubble (sll $0,$0,0).

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- stallF  in  1  hold PC (from hazard_unit)
- stallD  in  1  hold IF/ID register (from hazard_unit)
- flash  in  1  branch taken in EX: redirect PC, squash IF/ID
- branch_target  in  32  redirect address, valid when flash=1
- imem_addr  out  32  fetch address; always equals pc_F
- imem_req  out  1  fetch request
- imem_rdata  in  32  instruction word; valid when imem_ready=1
- imem_ready  in  1  memory returns imem_rdata for imem_addr this cycle
- instr_D  out  32  IF/ID instruction
- pc_plus4_D  out  32  IF/ID PC+4
- valid_D  out  1  IF/ID holds a real instruction
- fetch_wait  out  1  fetch outstanding and not returned this cycle; drives hazard_unit's stall input

Behaviour:
- Reset values:
  - pc_F=PC_RESET, state=RUN, imem_req=0 during the reset cycle.
  - instr_D=NOP_INSTR, pc_plus4_D=0, valid_D=0.
  - hold_instr=0, fetch_wait=0.
- stallD=1 implies PC hold, exactly as stallF=1 does; the two are normally asserted together.
- Per-cycle priority: reset > flash > stall > fetch.
- Arithmetic: pc+4 is 32-bit and wraps from 32'hFFFF_FFFC to 0. No alignment check; the low 2 bits of branch_target are passed through unchanged.
- State RUN (imem_req=1):
  - flash: pc_F<=branch_target; IF/ID<=bubble (NOP_INSTR, valid 0, pc_plus4 0); any imem_rdata this cycle is discarded; stay RUN.
  - stall & imem_ready: hold_instr<=imem_rdata; IF/ID held; pc_F held; go HELD.
  - stall & !imem_ready: IF/ID held; pc_F held; stay RUN and retry.
  - !stall & imem_ready: IF/ID<={imem_rdata, pc_F+4, valid 1}; pc_F<=pc_F+4.
  - !stall & !imem_ready: IF/ID<=bubble; pc_F held; fetch_wait=1.
- State HELD (imem_req=0, fetch_wait=0):
  - flash: hold discarded; pc_F<=branch_target; IF/ID<=bubble; go RUN.
  - stall: everything held; stay HELD.
  - !stall: IF/ID<={hold_instr, pc_F+4, valid 1}; pc_F<=pc_F+4; go RUN.
- fetch_wait is combinational: state==RUN & imem_req & !imem_ready & !flash.
- Latency: 1 cycle from imem_ready to instr_D; a flash bubble appears in the following cycle.
- Simultaneous flash+stall: flash wins, and the stall is ignored for that cycle.
- Reset mid-operation (HELD or waiting): hold is dropped and all reset values are restored in the next cycle.

Optional Feature:
- Macro: FETCH_PERF_EN.
- With the macro defined, three outputs are added, each 32-bit, saturating at 32'hFFFF_FFFF and cleared by reset:
  - perf_stall_cycles counts cycles with (stallF|stallD) & !flash.
  - perf_flush_count counts cycles with flash=1.
  - perf_miss_cycles counts cycles with fetch_wait=1.
- Without the macro, these ports and counters do not exist and behaviour is otherwise identical.

Decomposition:
- Shared package/header "newDefine.h" holds:
  - state encodings FS_RUN=1'b0, FS_HELD=1'b1.
  - the NOP_INSTR constant.
  - the PC_RESET default.
- Sub-module if_id_reg: the IF/ID register with hold, bubble-insert and reset. It is reused by later stage registers.

Test Plan:
- Reset, then imem_ready=1 for 3 cycles with rdata 0x20080001/0x20090002/0x200A0003 -> instr_D follows one cycle later; pc_plus4_D=4,8,12; valid_D=1; imem_addr=0,4,8,12.
- stallF=stallD=1 for 2 cycles while imem_ready=1 at pc=8 -> state HELD, imem_req=0, instr_D unchanged. On release, instr_D=hold word, pc_plus4_D=12, pc_F=12, with no re-fetch of address 8.
- imem_ready=0 for 3 cycles at pc=16 -> fetch_wait=1 for 3 cycles, valid_D=0 bubbles, imem_addr stays 16. Ready returns -> instr delivered, pc_F=20.
- flash=1, branch_target=0x40 while in HELD -> next cycle pc_F=0x40, valid_D=0, instr_D=0, state RUN, held word never appears.
- flash=1 and stallF=1 in the same cycle at pc=0x24 with branch_target=0x100 -> pc_F=0x100 and bubble. Separately, pc=32'hFFFF_FFFC fetch -> pc_F wraps to 0.
- FETCH_PERF_EN: 5 stall cycles, 2 flushes, 3 misses -> counters read 5/2/3. Reset clears all three to 0.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the IF stage: fetch FSM state encoding, bubble word and reset PC.
// Used by fetch_unit and its IF/ID register.
package fetch_unit_pkg;

   typedef enum logic {
      FS_RUN  = 1'b0,
      FS_HELD = 1'b1
   } fstate_t;

   localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;  // sll $0,$0,0
   localparam logic [31:0] PC_RESET_DEF  = 32'h0000_0000;

   // Sequential PC increment; wraps modulo 2^32 with no alignment check.
   function automatic logic [31:0] pc_inc(input logic [31:0] pc);
      return pc + 32'd4;
   endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory fetch bus between the IF stage (master) and instruction memory (slave).
interface fetch_unit_if;

   logic [31:0] imem_addr;
   logic        imem_req;
   logic [31:0] imem_rdata;
   logic        imem_ready;

   modport master (
      output imem_addr,
      output imem_req,
      input  imem_rdata,
      input  imem_ready
   );

   modport slave (
      input  imem_addr,
      input  imem_req,
      output imem_rdata,
      output imem_ready
   );

endinterface

// File: rtl/fetch_unit_if_id_reg.sv
// Pipeline stage register (instruction, PC+4, valid) with bubble insert, load and hold.
// Priority: reset > bubble > load > hold.
module if_id_reg
   import fetch_unit_pkg::*;
#(
   parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
   input  logic        clk,
   input  logic        i_reset,
   input  logic        i_bubble,
   input  logic        i_load,
   input  logic [31:0] i_instr,
   input  logic [31:0] i_pc_plus4,
   output logic [31:0] o_instr,
   output logic [31:0] o_pc_plus4,
   output logic        o_valid
);

   logic [31:0] r_instr;
   logic [31:0] r_pc_plus4;
   logic        r_valid;

   always_ff @(posedge clk) begin
      if (i_reset || i_bubble) begin
         r_instr    <= NOP_INSTR;
         r_pc_plus4 <= 32'd0;
         r_valid    <= 1'b0;
      end else if (i_load) begin
         r_instr    <= i_instr;
         r_pc_plus4 <= i_pc_plus4;
         r_valid    <= 1'b1;
      end
   end

   assign o_instr    = r_instr;
   assign o_pc_plus4 = r_pc_plus4;
   assign o_valid    = r_valid;

endmodule

// File: rtl/fetch_unit.sv
// MIPS IF stage with IF/ID register; buffers a word returned during a stall so it is never re-fetched.
// Optional performance counters are built when FETCH_PERF_EN is defined.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter logic [31:0] PC_RESET  = PC_RESET_DEF,
   parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         stallF,
   input  logic         stallD,
   input  logic         flash,
   input  logic [31:0]  branch_target,
   fetch_unit_if.master imem,
   output logic [31:0]  instr_D,
   output logic [31:0]  pc_plus4_D,
   output logic         valid_D,
   output logic         fetch_wait
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0]  perf_stall_cycles,
   output logic [31:0]  perf_flush_count,
   output logic [31:0]  perf_miss_cycles
`endif
);

   fstate_t     r_state;
   logic [31:0] r_pc;
   logic [31:0] r_hold_instr;

   logic        w_stall;
   logic [31:0] w_pc_plus4;
   logic        w_id_bubble;
   logic        w_id_load;
   logic [31:0] w_id_instr;

   assign w_stall    = stallF | stallD;
   assign w_pc_plus4 = pc_inc(r_pc);

   assign imem.imem_addr = r_pc;
   assign imem.imem_req  = (r_state == FS_RUN) && !reset;
   assign fetch_wait     = (r_state == FS_RUN) && imem.imem_req && !imem.imem_ready && !flash;

   // A returned-but-stalled word lives in r_hold_instr and is delivered instead of re-fetching.
   always_comb begin
      w_id_bubble = 1'b0;
      w_id_load   = 1'b0;
      w_id_instr  = imem.imem_rdata;
      if (flash) begin
         w_id_bubble = 1'b1;
      end else if (!w_stall) begin
         if (r_state == FS_HELD) begin
            w_id_load  = 1'b1;
            w_id_instr = r_hold_instr;
         end else if (imem.imem_ready) begin
            w_id_load = 1'b1;
         end else begin
            w_id_bubble = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_pc         <= PC_RESET;
         r_state      <= FS_RUN;
         r_hold_instr <= 32'd0;
      end else begin
         case (r_state)
            FS_RUN: begin
               if (flash) begin
                  r_pc <= branch_target;
               end else if (w_stall) begin
                  if (imem.imem_ready) begin
                     r_hold_instr <= imem.imem_rdata;
                     r_state      <= FS_HELD;
                  end
               end else if (imem.imem_ready) begin
                  r_pc <= w_pc_plus4;
               end
            end
            FS_HELD: begin
               if (flash) begin
                  r_pc         <= branch_target;
                  r_hold_instr <= 32'd0;
                  r_state      <= FS_RUN;
               end else if (!w_stall) begin
                  r_pc    <= w_pc_plus4;
                  r_state <= FS_RUN;
               end
            end
            default: r_state <= FS_RUN;
         endcase
      end
   end

   if_id_reg #(
      .NOP_INSTR (NOP_INSTR)
   ) u_if_id (
      .clk        (clk),
      .i_reset    (reset),
      .i_bubble   (w_id_bubble),
      .i_load     (w_id_load),
      .i_instr    (w_id_instr),
      .i_pc_plus4 (w_pc_plus4),
      .o_instr    (instr_D),
      .o_pc_plus4 (pc_plus4_D),
      .o_valid    (valid_D)
   );

`ifdef FETCH_PERF_EN
   logic [2:0]  w_perf_evt;
   logic [31:0] r_perf [3];

   assign w_perf_evt[0] = w_stall && !flash;
   assign w_perf_evt[1] = flash;
   assign w_perf_evt[2] = fetch_wait;

   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_perf
         always_ff @(posedge clk) begin
            if (reset) begin
               r_perf[gi] <= 32'd0;
            end else if (w_perf_evt[gi] && (r_perf[gi] != 32'hFFFF_FFFF)) begin
               r_perf[gi] <= r_perf[gi] + 32'd1;
            end
         end
      end
   endgenerate

   assign perf_stall_cycles = r_perf[0];
   assign perf_flush_count  = r_perf[1];
   assign perf_miss_cycles  = r_perf[2];
`endif

endmodule
